hsv_to_rgb: RTL and testbench

//  Pipelined HSV->RGB converter for the video path; inverse of the RGB->HSV stage
//  and takes its formats directly: H 0..359 deg, S 0..2047 (2047 = full), V 0..255.

---
 rtl/hsv_to_rgb.sv | 140 ++++++++++++++
 tb/tb_hsv_to_rgb.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hsv_to_rgb.sv
// Six-stage pipelined HSV -> RGB converter, one pixel per clock, fixed latency.
// Sideband and valid travel alongside the pixel; outputs hold while out_valid is low.
module hsv_to_rgb #(
    parameter int SB_W  = 3,
    parameter int ROUND = 1
) (
    input  logic            clk,
    input  logic            reset_b,
    input  logic            in_valid,
    input  logic [8:0]      H,
    input  logic [10:0]     S,
    input  logic [7:0]      V,
    input  logic [SB_W-1:0] in_sb,
    output logic            out_valid,
    output logic [7:0]      r,
    output logic [7:0]      g,
    output logic [7:0]      b,
    output logic [SB_W-1:0] out_sb
);
    localparam int LATENCY = 6;
    localparam logic [16:0] HALF_60   = 17'(30 * ROUND);
    localparam logic [19:0] HALF_2048 = 20'(1024 * ROUND);

    // floor(x/60) == floor(floor(x/4)/15); 559241/2^23 ~ 1/15 stays exact for x/4 < 79891
    function automatic logic [11:0] div60(input logic [16:0] x);
        return 12'(((35'(x) >> 2) * 35'd559241) >> 23);
    endfunction

    function automatic logic [7:0] scale_sat(input logic [18:0] x);
        logic [8:0] q;
        q = 9'(({1'b0, x} + HALF_2048) >> 11);
        return (q > 9'd255) ? 8'd255 : q[7:0];
    endfunction

    logic [LATENCY-2:0] vld;

    logic [8:0]  h1;
    logic [11:0] s1, s2, s3, s4;
    logic [7:0]  v1, v2, v3, v4, v5;
    logic [2:0]  sector2, sector3, sector4, sector5;
    logic [5:0]  f2;
    logic [16:0] m1_3, m2_3;
    logic [11:0] div_a4, div_b4;
    logic [18:0] p5, q5, t5;
    logic [SB_W-1:0] sb1, sb2, sb3, sb4, sb5;

    // Hue sector by compare chain; the remainder is the offset inside the sector.
    logic [2:0] sector_c;
    logic [8:0] base_c;
    logic [8:0] f_c;
    always_comb begin
        sector_c = 3'd0;
        base_c   = 9'd0;
        if      (h1 >= 9'd300) begin sector_c = 3'd5; base_c = 9'd300; end
        else if (h1 >= 9'd240) begin sector_c = 3'd4; base_c = 9'd240; end
        else if (h1 >= 9'd180) begin sector_c = 3'd3; base_c = 9'd180; end
        else if (h1 >= 9'd120) begin sector_c = 3'd2; base_c = 9'd120; end
        else if (h1 >= 9'd60)  begin sector_c = 3'd1; base_c = 9'd60;  end
        f_c = h1 - base_c;
    end

    // NOTE: only the valid chain and the outputs need reset; data registers are don't-care until valid arrives.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) vld <= '0;
        else          vld <= {vld[LATENCY-3:0], in_valid};
    end

    // NOTE: every clocked assignment is non-blocking so stages read the previous cycle's values.
    always_ff @(posedge clk) begin
        h1  <= (H >= 9'd360) ? H - 9'd360 : H;
        s1  <= (S == 11'd2047) ? 12'd2048 : {1'b0, S};
        v1  <= V;
        sb1 <= in_sb;

        sector2 <= sector_c;
        f2      <= f_c[5:0];
        s2      <= s1;
        v2      <= v1;
        sb2     <= sb1;

        m1_3    <= 17'(s2) * 17'(f2);
        m2_3    <= 17'(s2) * 17'(6'd60 - f2);
        s3      <= s2;
        v3      <= v2;
        sector3 <= sector2;
        sb3     <= sb2;

        div_a4  <= div60(m1_3 + HALF_60);
        div_b4  <= div60(m2_3 + HALF_60);
        s4      <= s3;
        v4      <= v3;
        sector4 <= sector3;
        sb4     <= sb3;

        p5      <= 19'(v4) * 19'(12'd2048 - s4);
        q5      <= 19'(v4) * 19'(12'd2048 - div_a4);
        t5      <= 19'(v4) * 19'(12'd2048 - div_b4);
        v5      <= v4;
        sector5 <= sector4;
        sb5     <= sb4;
    end

    logic [7:0] p_c, q_c, t_c;
    logic [7:0] r_c, g_c, b_c;
    always_comb begin
        p_c = scale_sat(p5);
        q_c = scale_sat(q5);
        t_c = scale_sat(t5);
        r_c = 8'd0;
        g_c = 8'd0;
        b_c = 8'd0;
        case (sector5)
            3'd0: begin r_c = v5;  g_c = t_c; b_c = p_c; end
            3'd1: begin r_c = q_c; g_c = v5;  b_c = p_c; end
            3'd2: begin r_c = p_c; g_c = v5;  b_c = t_c; end
            3'd3: begin r_c = p_c; g_c = q_c; b_c = v5;  end
            3'd4: begin r_c = t_c; g_c = p_c; b_c = v5;  end
            3'd5: begin r_c = v5;  g_c = p_c; b_c = q_c; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            out_valid <= 1'b0;
            r         <= 8'd0;
            g         <= 8'd0;
            b         <= 8'd0;
            out_sb    <= '0;
        end else begin
            out_valid <= vld[LATENCY-2];
            if (vld[LATENCY-2]) begin
                r      <= r_c;
                g      <= g_c;
                b      <= b_c;
                out_sb <= sb5;
            end
        end
    end
endmodule

// File: tb/tb_hsv_to_rgb.sv
// Directed and randomized checks of hsv_to_rgb against hand values and an integer model.
module tb_hsv_to_rgb;
    localparam int SB_W = 3;

    logic            clk = 1'b0;
    logic            reset_b;
    logic            in_valid;
    logic [8:0]      H;
    logic [10:0]     S;
    logic [7:0]      V;
    logic [SB_W-1:0] in_sb;
    logic            out_valid;
    logic [7:0]      r, g, b;
    logic [SB_W-1:0] out_sb;

    int errors = 0;
    int checks = 0;

    hsv_to_rgb #(.SB_W(SB_W), .ROUND(1)) dut (
        .clk(clk), .reset_b(reset_b), .in_valid(in_valid),
        .H(H), .S(S), .V(V), .in_sb(in_sb),
        .out_valid(out_valid), .r(r), .g(g), .b(b), .out_sb(out_sb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            valid;
        logic [23:0]     rgb;
        logic [SB_W-1:0] sb;
    } exp_t;

    function automatic int sat_shift(input int x);
        int q = (x + 1024) / 2048;
        return (q > 255) ? 255 : q;
    endfunction

    function automatic logic [23:0] model(input int h_in, input int s_in, input int v);
        int h = (h_in >= 360) ? h_in - 360 : h_in;
        int s = (s_in == 2047) ? 2048 : s_in;
        int sector = h / 60;
        int f = h - 60 * sector;
        int a = (s * f + 30) / 60;
        int bb = (s * (60 - f) + 30) / 60;
        int p = sat_shift(v * (2048 - s));
        int q = sat_shift(v * (2048 - a));
        int t = sat_shift(v * (2048 - bb));
        case (sector)
            0: return {8'(v), 8'(t), 8'(p)};
            1: return {8'(q), 8'(v), 8'(p)};
            2: return {8'(p), 8'(v), 8'(t)};
            3: return {8'(p), 8'(q), 8'(v)};
            4: return {8'(t), 8'(p), 8'(v)};
            default: return {8'(v), 8'(p), 8'(q)};
        endcase
    endfunction

    // Drive one pixel, then wait (bounded) for it to emerge; lat counts clocks to out_valid.
    task automatic run_pixel(input int h, input int s, input int v, input logic [SB_W-1:0] sb,
                             output logic [23:0] rgb, output logic [SB_W-1:0] sbo, output int lat);
        @(negedge clk);
        H = 9'(h); S = 11'(s); V = 8'(v); in_sb = sb; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rgb = {r, g, b};
        sbo = out_sb;
    endtask

    task automatic test_reset();
        reset_b = 1'b0; in_valid = 1'b1; H = 9'd10; S = 11'd100; V = 8'd50; in_sb = 3'b111;
        repeat (4) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || {r, g, b} !== 24'd0 || out_sb !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%b rgb=%h sb=%b, required 0/000000/000", out_valid, {r, g, b}, out_sb);
        end
        in_valid = 1'b0;
        reset_b = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_emit: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_gray();
        logic [23:0] rgb; logic [SB_W-1:0] sbo; int lat;
        run_pixel(200, 0, 200, 3'b101, rgb, sbo, lat);
        checks++;
        if (lat != 6 || rgb !== {8'd200, 8'd200, 8'd200} || sbo !== 3'b101) begin
            errors++;
            $display("FAIL gray: lat=%0d rgb=%h sb=%b, required 6/c8c8c8/101", lat, rgb, sbo);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || {r, g, b} !== {8'd200, 8'd200, 8'd200}) begin
            errors++;
            $display("FAIL hold: valid=%b rgb=%h, required 0/c8c8c8", out_valid, {r, g, b});
        end
    endtask

    task automatic test_primaries();
        logic [23:0] rgb; logic [SB_W-1:0] sbo; int lat;
        int          hs  [3] = '{0, 120, 240};
        logic [23:0] exp [3] = '{24'hff0000, 24'h00ff00, 24'h0000ff};
        for (int i = 0; i < 3; i++) begin
            run_pixel(hs[i], 2047, 255, 3'b001, rgb, sbo, lat);
            checks++;
            if (lat != 6 || rgb !== exp[i]) begin
                errors++;
                $display("FAIL primary_h%0d: lat=%0d rgb=%h, required 6/%h", hs[i], lat, rgb, exp[i]);
            end
        end
    endtask

    task automatic test_mid_sector();
        logic [23:0] rgb; logic [SB_W-1:0] sbo; int lat;
        run_pixel(30, 2047, 255, 3'b010, rgb, sbo, lat);
        checks++;
        if (rgb !== {8'd255, 8'd128, 8'd0}) begin
            errors++;
            $display("FAIL mid_h30: rgb=%h, required ff8000", rgb);
        end
        run_pixel(60, 2047, 255, 3'b010, rgb, sbo, lat);
        checks++;
        if (rgb !== {8'd255, 8'd255, 8'd0}) begin
            errors++;
            $display("FAIL mid_h60: rgb=%h, required ffff00", rgb);
        end
    endtask

    task automatic test_wrap();
        logic [23:0] rgb_a, rgb_b; logic [SB_W-1:0] sbo; int lat;
        run_pixel(40, 1500, 180, 3'b000, rgb_a, sbo, lat);
        checks++;
        if (rgb_a !== {8'd180, 8'd136, 8'd48}) begin
            errors++;
            $display("FAIL wrap_h40: rgb=%h, required b48830", rgb_a);
        end
        run_pixel(400, 1500, 180, 3'b000, rgb_b, sbo, lat);
        checks++;
        if (rgb_b !== {8'd180, 8'd136, 8'd48}) begin
            errors++;
            $display("FAIL wrap_h400: rgb=%h, required b48830", rgb_b);
        end
        run_pixel(359, 2047, 255, 3'b000, rgb_a, sbo, lat);
        checks++;
        if (rgb_a !== {8'd255, 8'd0, 8'd4}) begin
            errors++;
            $display("FAIL wrap_h359: rgb=%h, required ff0004", rgb_a);
        end
        run_pixel(360, 2047, 255, 3'b000, rgb_a, sbo, lat);
        checks++;
        if (rgb_a !== 24'hff0000) begin
            errors++;
            $display("FAIL wrap_h360: rgb=%h, required ff0000", rgb_a);
        end
        run_pixel(511, 1000, 100, 3'b000, rgb_a, sbo, lat);
        checks++;
        if (rgb_a !== model(151, 1000, 100)) begin
            errors++;
            $display("FAIL wrap_h511: rgb=%h, required %h", rgb_a, model(151, 1000, 100));
        end
    endtask

    task automatic test_boundaries();
        logic [23:0] rgb; logic [SB_W-1:0] sbo; int lat;
        run_pixel(300, 2047, 0, 3'b110, rgb, sbo, lat);
        checks++;
        if (rgb !== 24'd0 || sbo !== 3'b110) begin
            errors++;
            $display("FAIL v_zero: rgb=%h sb=%b, required 000000/110", rgb, sbo);
        end
        run_pixel(250, 1024, 77, 3'b011, rgb, sbo, lat);
        checks++;
        if (rgb !== model(250, 1024, 77)) begin
            errors++;
            $display("FAIL mid_s: rgb=%h, required %h", rgb, model(250, 1024, 77));
        end
    endtask

    task automatic test_back_to_back();
        exp_t q[$];
        exp_t e;
        int   sent = 0;
        int   cyc = 0;
        for (int i = 0; i < 6; i++) begin
            e.valid = 1'b0; e.rgb = '0; e.sb = '0;
            q.push_back(e);
        end
        while ((sent < 1000 || q.size() > 0) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            e = q.pop_front();
            checks++;
            if (out_valid !== e.valid || (e.valid && ({r, g, b} !== e.rgb || out_sb !== e.sb))) begin
                errors++;
                $display("FAIL stream_c%0d: valid=%b rgb=%h sb=%b, required %b/%h/%b",
                         cyc, out_valid, {r, g, b}, out_sb, e.valid, e.rgb, e.sb);
            end
            if (sent < 1000) begin
                H = 9'($urandom_range(0, 511));
                S = 11'($urandom_range(0, 2047));
                V = 8'($urandom_range(0, 255));
                in_sb = SB_W'($urandom);
                in_valid = ($urandom_range(0, 3) != 0);
                if (in_valid) sent++;
                e.valid = in_valid;
                e.rgb   = model(int'(H), int'(S), int'(V));
                e.sb    = in_sb;
                q.push_back(e);
            end else begin
                in_valid = 1'b0;
            end
        end
        checks++;
        if (sent != 1000 || q.size() != 0) begin
            errors++;
            $display("FAIL stream_budget: sent=%0d pending=%0d, required 1000/0", sent, q.size());
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [23:0] rgb; logic [SB_W-1:0] sbo; int lat;
        run_pixel(0, 2047, 255, 3'b111, rgb, sbo, lat);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            H = 9'(50 * i); S = 11'd2047; V = 8'd255; in_sb = 3'b111; in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2 reset_b = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || {r, g, b} !== 24'd0 || out_sb !== '0) begin
            errors++;
            $display("FAIL reset_async: valid=%b rgb=%h sb=%b, required 0/000000/000", out_valid, {r, g, b}, out_sb);
        end
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || {r, g, b} !== 24'd0) begin
                errors++;
                $display("FAIL reset_stale_c%0d: valid=%b rgb=%h, required 0/000000", i, out_valid, {r, g, b});
            end
        end
    endtask

    initial begin
        test_reset();
        test_gray();
        test_primaries();
        test_mid_sector();
        test_wrap();
        test_boundaries();
        test_back_to_back();
        test_reset_mid_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
